// File: rtl/itch_pkg.sv
// Shared ITCH assembler types, default sizes, message lengths and small arithmetic helpers.
// Pure declarations: no latency and no flow control of its own.
package itch_pkg;

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam int BEAT_BYTES_DEFAULT    = 8;
    localparam int MAX_MSG_BYTES_DEFAULT = 64;

    localparam int SYSTEM_EVENT_LEN    = 12;
    localparam int ORDER_CANCEL_LEN    = 23;
    localparam int ORDER_EXECUTED_LEN  = 31;
    localparam int ADD_ORDER_LEN       = 36;
    localparam int ADD_ORDER_MPID_LEN  = 40;

    function automatic int min_u(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/itch_msg_assembler_if.sv
// Beat-in / message-out bundle for the ITCH assembler; the source drives in_valid with no ready,
// so the assembler must accept every valid beat (stalls come only from in_valid low).
interface itch_msg_assembler_if
    import itch_pkg::*;
#(
    parameter int BEAT_BYTES    = BEAT_BYTES_DEFAULT,
    parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEFAULT
);
    localparam int OFF_W = $clog2(BEAT_BYTES);
    localparam int LEN_W = $clog2(MAX_MSG_BYTES + 1);

    logic                       in_valid;
    logic [8*BEAT_BYTES-1:0]    in_data;
    logic                       start;
    logic [OFF_W-1:0]           start_offset;
    logic [LEN_W-1:0]           msg_len;
    logic                       busy;
    logic                       last_beat;
    logic [OFF_W-1:0]           next_offset;
    logic                       out_valid;
    logic [8*MAX_MSG_BYTES-1:0] out_msg;
    logic [LEN_W-1:0]           out_len;
    logic                       err_len;
    logic                       err_abort;

    modport master (
        output in_valid, in_data, start, start_offset, msg_len,
        input  busy, last_beat, next_offset, out_valid, out_msg, out_len, err_len, err_abort
    );

    modport slave (
        input  in_valid, in_data, start, start_offset, msg_len,
        output busy, last_beat, next_offset, out_valid, out_msg, out_len, err_len, err_abort
    );

endinterface

// File: rtl/itch_byte_merge.sv
// Aligns a beat so byte src_off lands at buffer byte dst and flags the count bytes it covers.
// Combinational, zero latency, no flow control.
module itch_byte_merge #(
    parameter int BEAT_BYTES    = 8,
    parameter int MAX_MSG_BYTES = 64,
    parameter int OFF_W         = $clog2(BEAT_BYTES),
    parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic [8*BEAT_BYTES-1:0]    beat,
    input  logic [OFF_W-1:0]           src_off,
    input  logic [LEN_W-1:0]           dst,
    input  logic [LEN_W-1:0]           count,
    output logic [MAX_MSG_BYTES-1:0]   byte_en,
    output logic [8*MAX_MSG_BYTES-1:0] data
);

    logic [8*BEAT_BYTES-1:0] aligned;

    always_comb begin
        aligned = beat >> {src_off, 3'b000};
        data    = (8*MAX_MSG_BYTES)'(aligned) << {dst, 3'b000};
        // A shift by the full width yields zero, so count == MAX_MSG_BYTES enables every byte.
        byte_en = (~({MAX_MSG_BYTES{1'b1}} << count)) << dst;
    end

endmodule

// File: rtl/itch_msg_assembler.sv
// Gathers one ITCH message from an offset-aligned beat stream into a flat byte buffer.
// Final beat to out_valid is 1 cycle (2 for a message that starts and ends on another's final beat); stalls on in_valid low.
module itch_msg_assembler
    import itch_pkg::*;
#(
    parameter int BEAT_BYTES    = BEAT_BYTES_DEFAULT,
    parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEFAULT,
    parameter int OFF_W         = $clog2(BEAT_BYTES),
    parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    itch_msg_assembler_if.slave  bus
);

    localparam logic [LEN_W-1:0] BEAT_LEN = LEN_W'(BEAT_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_MSG_BYTES);

    state_t                     state;
    logic [8*MAX_MSG_BYTES-1:0] wbuf;
    logic [LEN_W-1:0]           fill;
    logic [LEN_W-1:0]           target;
    logic                       pend;
    logic                       out_valid_q;
    logic [8*MAX_MSG_BYTES-1:0] out_msg_q;
    logic [LEN_W-1:0]           out_len_q;
    logic                       err_len_q;
    logic                       err_abort_q;

    logic                       in_collect, do_start, len_ok, coll_last, b2b_ok, abort;
    logic                       old_done, new_ok, new_done;
    logic [LEN_W-1:0]           remaining, cont_take, avail, new_take;
    logic [OFF_W-1:0]           old_next_off, new_next_off;
    logic [MAX_MSG_BYTES-1:0]   cont_en, start_en;
    logic [8*MAX_MSG_BYTES-1:0] cont_dat, start_dat, cont_buf, start_buf;

    itch_byte_merge #(
        .BEAT_BYTES(BEAT_BYTES), .MAX_MSG_BYTES(MAX_MSG_BYTES), .OFF_W(OFF_W), .LEN_W(LEN_W)
    ) u_cont_merge (
        .beat(bus.in_data), .src_off('0), .dst(fill), .count(cont_take),
        .byte_en(cont_en), .data(cont_dat)
    );

    itch_byte_merge #(
        .BEAT_BYTES(BEAT_BYTES), .MAX_MSG_BYTES(MAX_MSG_BYTES), .OFF_W(OFF_W), .LEN_W(LEN_W)
    ) u_start_merge (
        .beat(bus.in_data), .src_off(bus.start_offset), .dst('0), .count(new_take),
        .byte_en(start_en), .data(start_dat)
    );

    always_comb begin
        in_collect   = (state == COLLECT);
        do_start     = bus.in_valid && bus.start;
        len_ok       = (bus.msg_len != '0) && (bus.msg_len <= MAX_LEN);
        remaining    = target - fill;
        cont_take    = LEN_W'(min_u(int'(remaining), BEAT_BYTES));
        old_next_off = remaining[OFF_W-1:0];
        coll_last    = in_collect && bus.in_valid && (remaining <= BEAT_LEN);
        // A start may share the final beat only if it begins after the old message's last byte.
        b2b_ok       = coll_last && (old_next_off != '0) && (bus.start_offset >= old_next_off);
        abort        = do_start && in_collect && !b2b_ok;
        old_done     = coll_last && !abort;
        avail        = BEAT_LEN - LEN_W'(bus.start_offset);
        new_take     = LEN_W'(min_u(int'(avail), int'(bus.msg_len)));
        new_ok       = do_start && len_ok;
        new_done     = new_ok && (bus.msg_len <= avail);
        new_next_off = bus.start_offset + bus.msg_len[OFF_W-1:0];
        cont_buf     = wbuf;
        start_buf    = '0;
        for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            cont_buf[8*i +: 8]  = cont_en[i]  ? cont_dat[8*i +: 8]  : wbuf[8*i +: 8];
            start_buf[8*i +: 8] = start_en[i] ? start_dat[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wbuf        <= '0;
            fill        <= '0;
            target      <= '0;
            pend        <= 1'b0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_len_q   <= '0;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
            // A message completed on the previous beat behind another one is delivered from wbuf now.
            if (pend) begin
                out_msg_q   <= wbuf;
                out_len_q   <= target;
                out_valid_q <= 1'b1;
                pend        <= 1'b0;
                wbuf        <= '0;
                fill        <= '0;
            end
            if (bus.in_valid) begin
                if (old_done) begin
                    out_msg_q   <= cont_buf;
                    out_len_q   <= target;
                    out_valid_q <= 1'b1;
                end
                if (do_start) begin
                    err_len_q   <= !len_ok;
                    err_abort_q <= abort;
                    if (new_ok && new_done) begin
                        state <= IDLE;
                        if (old_done || pend) begin
                            wbuf   <= start_buf;
                            target <= bus.msg_len;
                            fill   <= bus.msg_len;
                            pend   <= 1'b1;
                        end else begin
                            out_msg_q   <= start_buf;
                            out_len_q   <= bus.msg_len;
                            out_valid_q <= 1'b1;
                            wbuf        <= '0;
                            fill        <= '0;
                        end
                    end else if (new_ok) begin
                        state  <= COLLECT;
                        wbuf   <= start_buf;
                        fill   <= new_take;
                        target <= bus.msg_len;
                    end else begin
                        state <= IDLE;
                        wbuf  <= '0;
                        fill  <= '0;
                    end
                end else if (in_collect) begin
                    if (coll_last) begin
                        state <= IDLE;
                        wbuf  <= '0;
                        fill  <= '0;
                    end else begin
                        wbuf <= cont_buf;
                        fill <= fill + cont_take;
                    end
                end
            end
        end
    end

    assign bus.busy        = (state == COLLECT);
    assign bus.last_beat   = old_done || new_done;
    assign bus.next_offset = new_done ? new_next_off : (old_done ? old_next_off : '0);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_msg     = out_msg_q;
    assign bus.out_len     = out_len_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_abort   = err_abort_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Scoreboard bench for itch_msg_assembler: expected messages are queued as beats are driven
// and compared when out_valid pulses; each scenario task also checks its own control outputs.
module tb_itch_msg_assembler;
    import itch_pkg::*;

    localparam int BB = 8;
    localparam int MM = 64;
    localparam int OW = 3;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    itch_msg_assembler_if #(.BEAT_BYTES(BB), .MAX_MSG_BYTES(MM)) bus_if ();

    itch_msg_assembler #(.BEAT_BYTES(BB), .MAX_MSG_BYTES(MM), .OFF_W(OW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    typedef struct {
        logic [8*MM-1:0] msg;
        logic [LW-1:0]   len;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Stream byte at position p of a run is base + p; beat b holds positions 8b..8b+7.
    function automatic logic [8*BB-1:0] mk_beat(input logic [7:0] base, input int b);
        logic [8*BB-1:0] v;
        for (int k = 0; k < BB; k++) v[8*k +: 8] = base + 8'(8*b + k);
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] base, input int off, input int len);
        exp_t e;
        e.msg = '0;
        e.len = LW'(len);
        for (int i = 0; i < len; i++) e.msg[8*i +: 8] = base + 8'(off + i);
        return e;
    endfunction

    task automatic drive(input logic vld, input logic st, input int off, input int len,
                         input logic [8*BB-1:0] dat);
        bus_if.in_valid     = vld;
        bus_if.start        = st;
        bus_if.start_offset = OW'(off);
        bus_if.msg_len      = LW'(len);
        bus_if.in_data      = dat;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: out_valid=1 out_len=%0d, required no delivery", bus_if.out_len);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.out_msg !== e.msg || bus_if.out_len !== e.len) begin
                    errors++;
                    $display("FAIL out_msg: got len=%0d msg=%h, want len=%0d msg=%h",
                             bus_if.out_len, bus_if.out_msg, e.len, e.msg);
                end
            end
        end
    end

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.last_beat !== 1'b0) begin errors++; $display("FAIL reset_last_beat: got %b want 0", bus_if.last_beat); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
        checks++; if (bus_if.out_len !== '0) begin errors++; $display("FAIL reset_out_len: got %0d want 0", bus_if.out_len); end
        checks++; if (bus_if.out_msg !== '0) begin errors++; $display("FAIL reset_out_msg: got %h want 0", bus_if.out_msg); end
        checks++; if (bus_if.err_len !== 1'b0 || bus_if.err_abort !== 1'b0) begin
            errors++; $display("FAIL reset_err: got len=%b abort=%b want 0 0", bus_if.err_len, bus_if.err_abort);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        exp_q.push_back(mk_exp(8'h01, 0, 8));
        drive(1'b1, 1'b1, 0, 8, 64'h0807060504030201);
        @(negedge clk);
        checks++; if (bus_if.last_beat !== 1'b1 || bus_if.next_offset !== 3'd0) begin
            errors++; $display("FAIL single_last: got last=%b next=%0d want 1 0", bus_if.last_beat, bus_if.next_offset);
        end
        step();
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL single_latency: got out_valid=%b busy=%b want 1 0", bus_if.out_valid, bus_if.busy);
        end
        step();
    endtask

    task automatic test_multi_beat();
        int nb;
        nb = ceil_div(3 + ADD_ORDER_LEN, BB);
        exp_q.push_back(mk_exp(8'h00, 3, ADD_ORDER_LEN));
        for (int b = 0; b < nb; b++) begin
            drive(1'b1, b == 0, 3, ADD_ORDER_LEN, mk_beat(8'h00, b));
            @(negedge clk);
            checks++;
            if (b < nb - 1) begin
                if (bus_if.last_beat !== 1'b0) begin errors++; $display("FAIL multi_last_early: beat %0d got last=1 want 0", b); end
            end else if (bus_if.last_beat !== 1'b1 || bus_if.next_offset !== 3'd7) begin
                errors++; $display("FAIL multi_last: got last=%b next=%0d want 1 7", bus_if.last_beat, bus_if.next_offset);
            end
            step();
        end
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL multi_done: got out_valid=%b busy=%b want 1 0", bus_if.out_valid, bus_if.busy);
        end
        step();
    endtask

    task automatic test_stall();
        exp_q.push_back(mk_exp(8'h00, 3, ADD_ORDER_LEN));
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, b == 0, 3, ADD_ORDER_LEN, mk_beat(8'h00, b));
            step();
            if (b == 1) begin
                for (int s = 0; s < 2; s++) begin
                    idle();
                    @(negedge clk);
                    checks++; if (bus_if.busy !== 1'b1 || bus_if.last_beat !== 1'b0 || bus_if.out_valid !== 1'b0) begin
                        errors++; $display("FAIL stall_hold: got busy=%b last=%b out_valid=%b want 1 0 0",
                                           bus_if.busy, bus_if.last_beat, bus_if.out_valid);
                    end
                    step();
                end
            end
        end
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL stall_done: got out_valid=%b want 1", bus_if.out_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(mk_exp(8'h40, 0, SYSTEM_EVENT_LEN));
        exp_q.push_back(mk_exp(8'h40, 12, 4));
        drive(1'b1, 1'b1, 0, SYSTEM_EVENT_LEN, mk_beat(8'h40, 0));
        step();
        drive(1'b1, 1'b1, 4, 4, mk_beat(8'h40, 1));
        @(negedge clk);
        checks++; if (bus_if.last_beat !== 1'b1 || bus_if.next_offset !== 3'd0) begin
            errors++; $display("FAIL b2b_last: got last=%b next=%0d want 1 0", bus_if.last_beat, bus_if.next_offset);
        end
        step();
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_len !== 7'd12 || bus_if.err_abort !== 1'b0 || bus_if.err_len !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got valid=%b len=%0d abort=%b errlen=%b want 1 12 0 0",
                               bus_if.out_valid, bus_if.out_len, bus_if.err_abort, bus_if.err_len);
        end
        step();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_len !== 7'd4 || bus_if.err_abort !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got valid=%b len=%0d abort=%b want 1 4 0",
                               bus_if.out_valid, bus_if.out_len, bus_if.err_abort);
        end
        step();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got out_valid=%b want 0", bus_if.out_valid); end
        step();
    endtask

    task automatic test_err_len();
        int len;
        for (int t = 0; t < 2; t++) begin
            len = (t == 0) ? 0 : MM + 1;
            drive(1'b1, 1'b1, 0, len, mk_beat(8'hA0, 0));
            @(negedge clk);
            checks++; if (bus_if.last_beat !== 1'b0) begin errors++; $display("FAIL errlen_last: len %0d got last=1 want 0", len); end
            step();
            idle();
            @(negedge clk);
            checks++; if (bus_if.err_len !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
                errors++; $display("FAIL errlen_pulse: len %0d got err=%b valid=%b busy=%b want 1 0 0",
                                   len, bus_if.err_len, bus_if.out_valid, bus_if.busy);
            end
            step();
            @(negedge clk);
            checks++; if (bus_if.err_len !== 1'b0) begin errors++; $display("FAIL errlen_clear: len %0d got err=1 want 0", len); end
        end
        step();
    endtask

    task automatic test_abort();
        drive(1'b1, 1'b1, 0, ADD_ORDER_LEN, mk_beat(8'h80, 0));
        step();
        exp_q.push_back(mk_exp(8'h88, 2, 10));
        drive(1'b1, 1'b1, 2, 10, mk_beat(8'h80, 1));
        @(negedge clk);
        checks++; if (bus_if.last_beat !== 1'b0) begin errors++; $display("FAIL abort_last: got last=1 want 0"); end
        step();
        drive(1'b1, 1'b0, 0, 0, mk_beat(8'h80, 2));
        @(negedge clk);
        checks++; if (bus_if.err_abort !== 1'b1 || bus_if.busy !== 1'b1) begin
            errors++; $display("FAIL abort_pulse: got abort=%b busy=%b want 1 1", bus_if.err_abort, bus_if.busy);
        end
        checks++; if (bus_if.last_beat !== 1'b1 || bus_if.next_offset !== 3'd4) begin
            errors++; $display("FAIL abort_new_last: got last=%b next=%0d want 1 4", bus_if.last_beat, bus_if.next_offset);
        end
        step();
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.err_abort !== 1'b0) begin
            errors++; $display("FAIL abort_deliver: got valid=%b abort=%b want 1 0", bus_if.out_valid, bus_if.err_abort);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 3, ADD_ORDER_LEN, mk_beat(8'h00, 0));
        step();
        drive(1'b1, 1'b0, 3, ADD_ORDER_LEN, mk_beat(8'h00, 1));
        step();
        drive(1'b1, 1'b0, 3, ADD_ORDER_LEN, mk_beat(8'h00, 2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0 || bus_if.err_len !== 1'b0 || bus_if.err_abort !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got busy=%b valid=%b errlen=%b abort=%b want 0 0 0 0",
                               bus_if.busy, bus_if.out_valid, bus_if.err_len, bus_if.err_abort);
        end
        checks++; if (bus_if.out_msg !== '0 || bus_if.out_len !== '0) begin
            errors++; $display("FAIL rstmid_out: got len=%0d msg=%h want 0 0", bus_if.out_len, bus_if.out_msg);
        end
        step();
        exp_q.push_back(mk_exp(8'h20, 0, 8));
        drive(1'b1, 1'b1, 0, 8, mk_beat(8'h20, 0));
        @(negedge clk);
        checks++; if (bus_if.last_beat !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_last: got last=0 want 1"); end
        step();
        idle();
        @(negedge clk);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_done: got out_valid=0 want 1"); end
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_stall();
        test_back_to_back();
        test_err_len();
        test_abort();
        test_reset_mid();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d undelivered messages, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/itch_msg_assembler.md
Name: itch_msg_assembler

Overview:
Parametrised successor to the per-message ITCH field parsers. It gathers one ITCH message of run-time length from a beat stream at an arbitrary byte offset into a flat little-endian byte buffer, then presents it with a completion pulse. It also hands the byte offset of the following message to the downstream dispatcher. It sits between the beat source and per-type field decoders, so decoders slice fixed byte positions and no longer handle alignment themselves.

Parameters:
BEAT_BYTES, 8, bytes per input beat (power of 2, >=2)
MAX_MSG_BYTES, 64, largest accepted message length in bytes
OFF_W, $clog2(BEAT_BYTES), byte-offset width
LEN_W, $clog2(MAX_MSG_BYTES+1), length width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  in_data holds a beat this cycle
in_data  in  8*BEAT_BYTES  beat; byte k = in_data[8k+7:8k]
start  in  1  qualified by in_valid; first message byte is in this beat
start_offset  in  OFF_W  byte index of first message byte in the start beat
msg_len  in  LEN_W  message length in bytes, sampled with start
busy  out  1  message collection in progress
last_beat  out  1  combinational; current beat completes the message
next_offset  out  OFF_W  combinational, valid with last_beat; byte index of the first unused byte in this beat (0 = next message starts on next beat)
out_valid  out  1  one-cycle pulse; out_msg/out_len valid
out_msg  out  8*MAX_MSG_BYTES  message byte i at [8i+7:8i]; bytes >= out_len are zero
out_len  out  LEN_W  length of delivered message
err_len  out  1  one-cycle pulse; start had msg_len==0 or >MAX_MSG_BYTES
err_abort  out  1  one-cycle pulse; start arrived on a non-final beat while busy

Behaviour:
- Reset: state IDLE; all outputs, working buffer and counters are zero. Reset mid-COLLECT discards the partial message with no out_valid and no err pulse.
- States are IDLE and COLLECT. Working buffer, fill count (LEN_W) and target length are registered. out_msg/out_len are a separate output register.
- Accepting a beat requires in_valid=1. A cycle with in_valid=0 stalls: no state change and last_beat=0.
- Start, accepted in IDLE, or in COLLECT only on the final beat (see below):
  - Invalid msg_len: err_len next cycle; stay or return to IDLE.
  - Otherwise take avail = BEAT_BYTES - start_offset and copy bytes start_offset..start_offset+min(avail,msg_len)-1 to buffer bytes 0.. .
  - If msg_len <= avail, last_beat=1 and next_offset = (start_offset+msg_len) mod BEAT_BYTES. Otherwise go to COLLECT.
- COLLECT, each accepted beat:
  - take = min(BEAT_BYTES, remaining); copy beat bytes 0..take-1 to buffer bytes fill..fill+take-1.
  - When remaining <= BEAT_BYTES: last_beat=1, next_offset = remaining mod BEAT_BYTES, return to IDLE.
- Completion: out_valid pulses the cycle after last_beat. out_msg holds the buffer with bytes >= len zeroed. out_msg/out_len hold until the next completion. Working buffer and fill clear.
- Total beats for a message = ceil((start_offset+msg_len)/BEAT_BYTES). Latency from final beat to out_valid is 1 cycle.
- Back-to-back: start on the final beat with start_offset >= next_offset (next_offset!=0) is legal. The old message completes normally and the new one begins from start_offset in the same cycle, so there are no bubbles.
  - start_offset < next_offset in that case: treat as err_abort; the new message is still captured.
- start on a non-final COLLECT beat: err_abort next cycle, partial message dropped, new message captured from this beat.
- busy=1 exactly while in COLLECT.
- All arithmetic is unsigned LEN_W; fill never exceeds MAX_MSG_BYTES.

Decomposition:
- Shared package itch_pkg holds:
  - state enum {IDLE, COLLECT}
  - BEAT_BYTES default constant
  - ITCH message-length constants (e.g. ADD_ORDER_MPID_LEN)
  - min/ceil-div helper functions
- One sub-module, itch_byte_merge: combinational. Takes a beat, source offset, destination fill and byte count; produces the byte-enable mask and shifted data for the working buffer.

Test Plan:
- BEAT_BYTES=8, start_offset=0, msg_len=8, in_data=0x0807060504030201 -> last_beat same cycle, next_offset=0; next cycle out_valid, out_msg[63:0]=0x0807060504030201, upper bytes 0, out_len=8.
- start_offset=3, msg_len=36, beats carry incrementing bytes 0x00.. -> 5 beats, last_beat on 5th with next_offset=7; out_msg byte i = 0x03+i for i<36.
- Same as the 36-byte case with in_valid low 2 cycles after beat 2 -> identical out_msg, out_valid 2 cycles later, busy held.
- Msg A offset 0 len 12 ends at byte 4 of beat 2; start on that beat with offset 4, len 4 -> A out_valid next cycle, B out_valid the following cycle, B bytes = beat2 bytes 4..7, no errors.
- msg_len=0 and msg_len=65 -> err_len pulse, no out_valid, busy=0. start on beat 2 of a 36-byte message -> err_abort, new message delivered correctly.
- rst asserted on beat 3 of the 36-byte message -> all outputs 0 next cycle; a fresh 8-byte message then completes normally.
